// File: rtl/snappy_sync_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : snappy_sync_fifo_if
//  Brief    : Write/read/status bundle for snappy_sync_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
interface snappy_sync_fifo_if #(
  parameter int WIDTH = 89,
  parameter int DEPTH = 8
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   din;
  logic               wr_en;
  logic               full;
  logic               almost_full;
  logic               prog_full;
  logic               overflow;
  logic               rd_en;
  logic [WIDTH-1:0]   dout;
  logic               valid;
  logic               empty;
  logic               underflow;
  logic [c_CNT_W-1:0] data_count;

  modport master (
    output din, wr_en, rd_en,
    input  full, almost_full, prog_full, overflow,
    input  dout, valid, empty, underflow, data_count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, almost_full, prog_full, overflow,
    output dout, valid, empty, underflow, data_count
  );
endinterface
`default_nettype wire

// File: rtl/snappy_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : snappy_sync_fifo
//  Brief    : Single-clock FIFO with standard or FWFT read, all status
//             derived from one occupancy counter.
//  Revision : 1.0 - initial release
// ============================================================================
module snappy_sync_fifo #(
  parameter int WIDTH            = 89,
  parameter int DEPTH            = 8,
  parameter int PROG_FULL_THRESH = 3,
  parameter int FWFT             = 0
) (
  input  logic              clk,
  input  logic              srst,
  snappy_sync_fifo_if.slave bus
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL_CNT  = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_AFULL_CNT = c_CW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_PFULL_CNT = c_CW'(PROG_FULL_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_head;

  assign w_full   = (r_count == c_FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Accept decisions look only at start-of-cycle occupancy, never at the
  // opposite port, so full rejects writes and empty rejects reads outright.
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_acc && !srst) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
    end
  end

  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (r_count >= c_AFULL_CNT);
  assign bus.prog_full   = (r_count >= c_PFULL_CNT);
  assign bus.data_count  = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout  = w_head;
      assign bus.valid = !w_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      logic             r_valid;

      always_ff @(posedge clk) begin
        if (srst) begin
          r_dout  <= '0;
          r_valid <= 1'b0;
        end else begin
          if (w_rd_acc) r_dout <= w_head;
          r_valid <= w_rd_acc;
        end
      end

      assign bus.dout  = r_dout;
      assign bus.valid = r_valid;
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_snappy_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snappy_sync_fifo
//  Brief    : Drives a standard and an FWFT instance with identical traffic
//             and compares both against a queue-based reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snappy_sync_fifo;
  localparam int c_W  = 89;
  localparam int c_D  = 8;
  localparam int c_PT = 3;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  snappy_sync_fifo_if #(.WIDTH(c_W), .DEPTH(c_D)) if_std ();
  snappy_sync_fifo_if #(.WIDTH(c_W), .DEPTH(c_D)) if_fwft ();

  snappy_sync_fifo #(.WIDTH(c_W), .DEPTH(c_D), .PROG_FULL_THRESH(c_PT), .FWFT(0)) u_std (
    .clk (clk),
    .srst(srst),
    .bus (if_std.slave)
  );

  snappy_sync_fifo #(.WIDTH(c_W), .DEPTH(c_D), .PROG_FULL_THRESH(c_PT), .FWFT(1)) u_fwft (
    .clk (clk),
    .srst(srst),
    .bus (if_fwft.slave)
  );

  // Reference: FIFO contents as a plain queue plus the registered std outputs.
  logic [c_W-1:0] q[$];
  logic [c_W-1:0] exp_dout;
  logic           exp_valid;
  logic           exp_ovf;
  logic           exp_udf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_eq("std.data_count", 128'(if_std.data_count), 128'(n));
    check_eq("std.empty",      128'(if_std.empty),       128'(n == 0));
    check_eq("std.full",       128'(if_std.full),        128'(n == c_D));
    check_eq("std.almost_full",128'(if_std.almost_full), 128'(n >= c_D - 1));
    check_eq("std.prog_full",  128'(if_std.prog_full),   128'(n >= c_PT));
    check_eq("std.overflow",   128'(if_std.overflow),    128'(exp_ovf));
    check_eq("std.underflow",  128'(if_std.underflow),   128'(exp_udf));
    check_eq("std.valid",      128'(if_std.valid),       128'(exp_valid));
    check_eq("std.dout",       128'(if_std.dout),        128'(exp_dout));
    check_eq("fwft.data_count",128'(if_fwft.data_count), 128'(n));
    check_eq("fwft.valid",     128'(if_fwft.valid),      128'(n != 0));
    check_eq("fwft.overflow",  128'(if_fwft.overflow),   128'(exp_ovf));
    check_eq("fwft.underflow", 128'(if_fwft.underflow),  128'(exp_udf));
    if (n != 0) check_eq("fwft.dout", 128'(if_fwft.dout), 128'(q[0]));
  endtask

  // One clock cycle: drive both instances, advance the model, check after the edge.
  task automatic cycle(input logic wr, input logic rd, input logic rst, input logic [c_W-1:0] d);
    int  n;
    logic wok, rok;
    srst          = rst;
    if_std.wr_en  = wr;
    if_std.rd_en  = rd;
    if_std.din    = d;
    if_fwft.wr_en = wr;
    if_fwft.rd_en = rd;
    if_fwft.din   = d;
    n = q.size();
    if (rst) begin
      q.delete();
      exp_dout  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      wok       = wr && (n < c_D);
      rok       = rd && (n > 0);
      exp_ovf   = wr && (n == c_D);
      exp_udf   = rd && (n == 0);
      exp_valid = rok;
      if (rok) exp_dout = q.pop_front();
      if (wok) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [c_W-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[c_W-1:0];
  endfunction

  initial begin
    srst = 1'b1;
    if_std.wr_en = 1'b0;  if_std.rd_en = 1'b0;  if_std.din = '0;
    if_fwft.wr_en = 1'b0; if_fwft.rd_en = 1'b0; if_fwft.din = '0;

    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b1, '1);

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < c_D; i++) cycle(1'b1, 1'b0, 1'b0, c_W'(i));
    cycle(1'b1, 1'b0, 1'b0, c_W'(32'hDEAD));
    for (int i = 0; i < c_D; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Simultaneous access at the full and empty boundaries.
    for (int i = 0; i < c_D; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
    cycle(1'b1, 1'b1, 1'b0, rand_word());
    for (int i = 0; i < c_D - 1; i++) cycle(1'b0, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, rand_word());
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Steady state at occupancy 3 across the pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, c_W'(100 + i));
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, c_W'(200 + i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0);

    // Fall-through of a single word, then pop to empty.
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b0, c_W'(8'hA5));
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Reset with five words stored and a write pending.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
    cycle(1'b1, 1'b0, 1'b1, rand_word());
    cycle(1'b1, 1'b0, 1'b0, c_W'(8'h3C));
    cycle(1'b0, 1'b1, 1'b0, '0);

    // Random traffic with shifting write/read bias and occasional resets.
    for (int ph = 0; ph < 6; ph++) begin
      int wp, rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int i = 0; i < 100; i++) begin
        cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) == 0, rand_word());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
